// File: rtl/quad_step_decoder.sv
// Quadrature/index front end: synchronise and glitch-filter A/B/index, then decode
// Gray-code transitions into step/direction pulses, index clears and error counts.

module qsd_filter_ch #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  input  logic warm_i,
  output logic filt_o
);
  localparam logic [3:0] CNT_LAST = 4'(FILT_LEN - 1);

  logic       s1_q, s2_q, filt_q;
  logic [3:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
      // During warm-up the filter is bypassed so it starts out on the pin levels
      if (warm_i) begin
        filt_q <= s2_q;
        cnt_q  <= '0;
      end else if (s2_q == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        filt_q <= s2_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  assign filt_o = filt_q;
endmodule

module quad_step_decoder #(
  parameter int FILT_LEN = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             idx_in,
  input  logic             enable,
  input  logic             clr_err,
  output logic             step_en,
  output logic             step_up,
  output logic             idx_clr,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       ab_state
);
  localparam logic [4:0]       WU_N    = 5'(FILT_LEN + 2);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  // channel 2 = A, 1 = B, 0 = index
  logic [2:0] raw, filt;
  logic [4:0] wu_q;
  logic       warm;

  assign raw  = {a_in, b_in, idx_in};
  assign warm = (wu_q != WU_N);

  for (genvar c = 0; c < 3; c++) begin : g_ch
    qsd_filter_ch #(.FILT_LEN(FILT_LEN)) u_filt (
      .clk   (clk),
      .reset (reset),
      .raw_i (raw[c]),
      .warm_i(warm),
      .filt_o(filt[c])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     wu_q <= '0;
    else if (warm) wu_q <= wu_q + 5'd1;
  end

  logic [1:0]       cur, prev_q, fwd_nxt, chg;
  logic             prev_idx_q;
  logic             single, dbl;
  logic             step_en_d, step_up_d, idx_clr_d, err_pulse_d;
  logic             step_en_q, step_up_q, idx_clr_q, err_pulse_q;
  logic [ERR_W-1:0] err_cnt_d, err_cnt_q;

  assign cur = filt[2:1];
  assign chg = cur ^ prev_q;

  always_comb begin
    fwd_nxt     = 2'b00;
    case (prev_q)
      2'b00: fwd_nxt = 2'b10;
      2'b10: fwd_nxt = 2'b11;
      2'b11: fwd_nxt = 2'b01;
      2'b01: fwd_nxt = 2'b00;
      default: fwd_nxt = 2'b00;
    endcase
    single      = (chg == 2'b01) || (chg == 2'b10);
    dbl         = (chg == 2'b11);
    step_en_d   = single & enable & ~warm;
    step_up_d   = (single & ~warm) ? (cur == fwd_nxt) : step_up_q;
    idx_clr_d   = filt[0] & ~prev_idx_q & (cur == 2'b00) & enable & ~warm;
    err_pulse_d = dbl & ~warm;
    err_cnt_d   = err_cnt_q;
    if (clr_err)                                err_cnt_d = '0;
    else if (err_pulse_d && err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q      <= '0;
      prev_idx_q  <= 1'b0;
      step_en_q   <= 1'b0;
      step_up_q   <= 1'b0;
      idx_clr_q   <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      prev_q      <= cur;
      prev_idx_q  <= filt[0];
      step_en_q   <= step_en_d;
      step_up_q   <= step_up_d;
      idx_clr_q   <= idx_clr_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign step_en   = step_en_q;
  assign step_up   = step_up_q;
  assign idx_clr   = idx_clr_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign ab_state  = filt[2:1];
endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder (FILT_LEN=4, ERR_W=2).

module tb_quad_step_decoder;
  logic       clk = 1'b0;
  logic       reset, a_in, b_in, idx_in, enable, clr_err;
  logic       step_en, step_up, idx_clr, err_pulse;
  logic [1:0] err_cnt, ab_state;

  int checks = 0, failures = 0;
  int n_en, en_k, up_at, n_err, err_k, n_idx, idx_k;

  quad_step_decoder #(.FILT_LEN(4), .ERR_W(2)) dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .idx_in(idx_in),
    .enable(enable), .clr_err(clr_err), .step_en(step_en), .step_up(step_up),
    .idx_clr(idx_clr), .err_pulse(err_pulse), .err_cnt(err_cnt), .ab_state(ab_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive pins, run ncyc cycles and record pulse counts and the cycle of first pulse.
  // Cycle k=1 is sampled just after the edge where s1 captures the new levels.
  task automatic run_seg(input logic a, input logic b, input logic idx, input int ncyc);
    a_in = a; b_in = b; idx_in = idx;
    n_en = 0; en_k = -1; up_at = -1; n_err = 0; err_k = -1; n_idx = 0; idx_k = -1;
    for (int k = 1; k <= ncyc; k++) begin
      tick();
      if (step_en) begin
        n_en++;
        if (en_k < 0) begin en_k = k; up_at = int'(step_up); end
      end
      if (err_pulse) begin n_err++; if (err_k < 0) err_k = k; end
      if (idx_clr)   begin n_idx++; if (idx_k < 0) idx_k = k; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; a_in = 0; b_in = 0; idx_in = 0; enable = 1; clr_err = 0;
    repeat (3) tick();
    checks++;
    if ({step_en, step_up, idx_clr, err_pulse, err_cnt, ab_state} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=00000000",
               {step_en, step_up, idx_clr, err_pulse, err_cnt, ab_state});
    end
    reset = 1'b0;
    run_seg(0, 0, 0, 20);
    checks++;
    if (n_en !== 0 || n_err !== 0 || n_idx !== 0) begin
      failures++;
      $display("FAIL reset_warmup_quiet en=%0d err=%0d idx=%0d exp=0/0/0", n_en, n_err, n_idx);
    end
  endtask

  task automatic test_forward();
    logic [1:0] seq [4];
    seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    for (int i = 0; i < 4; i++) begin
      run_seg(seq[i][1], seq[i][0], 0, 20);
      checks++;
      if (n_en !== 1 || en_k !== 7) begin
        failures++;
        $display("FAIL fwd_step[%0d] count=%0d at=%0d exp count=1 at=7", i, n_en, en_k);
      end
      checks++;
      if (up_at !== 1) begin
        failures++;
        $display("FAIL fwd_dir[%0d] step_up=%0d exp=1", i, up_at);
      end
      checks++;
      if (ab_state !== seq[i] || n_err !== 0) begin
        failures++;
        $display("FAIL fwd_state[%0d] ab=%b err=%0d exp ab=%b err=0", i, ab_state, n_err, seq[i]);
      end
    end
  endtask

  task automatic test_reverse_glitch();
    logic [1:0] seq [4];
    seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    for (int i = 0; i < 4; i++) begin
      run_seg(seq[i][1], seq[i][0], 0, 20);
      checks++;
      if (n_en !== 1 || en_k !== 7 || up_at !== 0) begin
        failures++;
        $display("FAIL rev_step[%0d] count=%0d at=%0d up=%0d exp 1/7/0", i, n_en, en_k, up_at);
      end
      checks++;
      if (ab_state !== seq[i]) begin
        failures++;
        $display("FAIL rev_state[%0d] ab=%b exp=%b", i, ab_state, seq[i]);
      end
    end
    run_seg(1, 0, 0, 3);
    run_seg(0, 0, 0, 20);
    checks++;
    if (n_en !== 0 || n_err !== 0 || ab_state !== 2'b00) begin
      failures++;
      $display("FAIL glitch_reject en=%0d err=%0d ab=%b exp 0/0/00", n_en, n_err, ab_state);
    end
  endtask

  task automatic test_errors();
    for (int n = 1; n <= 5; n++) begin
      logic v;
      v = n[0];
      run_seg(v, v, 0, 20);
      checks++;
      if (n_err !== 1 || err_k !== 7 || n_en !== 0) begin
        failures++;
        $display("FAIL err_jump[%0d] err=%0d at=%0d en=%0d exp 1/7/0", n, n_err, err_k, n_en);
      end
      checks++;
      if (err_cnt !== 2'((n > 3) ? 3 : n)) begin
        failures++;
        $display("FAIL err_cnt[%0d] got=%0d exp=%0d", n, err_cnt, (n > 3) ? 3 : n);
      end
    end
    // 6th jump 11->00 with clr_err landing on the increment edge
    a_in = 0; b_in = 0;
    repeat (6) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if (err_pulse !== 1'b1 || err_cnt !== 2'd0) begin
      failures++;
      $display("FAIL err_clr_priority pulse=%b cnt=%0d exp pulse=1 cnt=0", err_pulse, err_cnt);
    end
    repeat (13) tick();
    checks++;
    if (err_cnt !== 2'd0 || ab_state !== 2'b00) begin
      failures++;
      $display("FAIL err_clr_hold cnt=%0d ab=%b exp 0/00", err_cnt, ab_state);
    end
  endtask

  task automatic test_index_enable();
    run_seg(0, 0, 1, 20);
    checks++;
    if (n_idx !== 1 || idx_k !== 7) begin
      failures++;
      $display("FAIL idx_at_00 count=%0d at=%0d exp 1/7", n_idx, idx_k);
    end
    run_seg(0, 0, 0, 20);
    enable = 1'b0;
    run_seg(1, 0, 0, 20);
    run_seg(1, 1, 0, 20);
    checks++;
    if (n_en !== 0 || ab_state !== 2'b11) begin
      failures++;
      $display("FAIL enable_off en=%0d ab=%b exp 0/11", n_en, ab_state);
    end
    enable = 1'b1;
    run_seg(1, 1, 0, 20);
    checks++;
    if (n_en !== 0) begin
      failures++;
      $display("FAIL reenable_stale en=%0d exp=0", n_en);
    end
    run_seg(1, 1, 1, 20);
    checks++;
    if (n_idx !== 0 || n_err !== 0) begin
      failures++;
      $display("FAIL idx_at_11 idx=%0d err=%0d exp 0/0", n_idx, n_err);
    end
    run_seg(0, 1, 0, 20);
    checks++;
    if (n_en !== 1 || en_k !== 7 || up_at !== 1) begin
      failures++;
      $display("FAIL reenable_step count=%0d at=%0d up=%0d exp 1/7/1", n_en, en_k, up_at);
    end
    run_seg(0, 0, 0, 20);
  endtask

  task automatic test_reset_warmup();
    run_seg(1, 0, 0, 7);
    checks++;
    if (en_k !== 7) begin
      failures++;
      $display("FAIL midreset_pre step_at=%0d exp=7", en_k);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({step_en, step_up, idx_clr, err_pulse, err_cnt, ab_state} !== 8'h00) begin
      failures++;
      $display("FAIL midreset_async got=%b exp=00000000",
               {step_en, step_up, idx_clr, err_pulse, err_cnt, ab_state});
    end
    a_in = 1; b_in = 1;
    repeat (4) tick();
    reset = 1'b0;
    n_en = 0; n_err = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (step_en)   n_en++;
      if (err_pulse) n_err++;
      if (k == 6) begin
        checks++;
        if (ab_state !== 2'b11) begin
          failures++;
          $display("FAIL warmup_state ab=%b exp=11", ab_state);
        end
      end
    end
    checks++;
    if (n_en !== 0 || n_err !== 0 || err_cnt !== 2'd0) begin
      failures++;
      $display("FAIL warmup_quiet en=%0d err=%0d cnt=%0d exp 0/0/0", n_en, n_err, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse_glitch();
    test_errors();
    test_index_enable();
    test_reset_warmup();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
